// File: rtl/mcu_pkg.sv
// Shared definitions for the 8051 interrupt sequencing logic.
//   - source index constants (fixed 0>1>2>3>4 order inside a priority level)
//   - vector base and stride
//   - int_ctrl state encoding
//   - helpers for vector address and hardware flag-clear masks
package mcu_pkg;

  localparam int          INT_NSRC       = 5;
  localparam logic [15:0] INT_VEC_BASE   = 16'h0003;
  localparam logic [15:0] INT_VEC_STRIDE = 16'd8;

  localparam logic [2:0] SRC_IE0 = 3'd0;
  localparam logic [2:0] SRC_TF0 = 3'd1;
  localparam logic [2:0] SRC_IE1 = 3'd2;
  localparam logic [2:0] SRC_TF1 = 3'd3;
  localparam logic [2:0] SRC_SER = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } int_state_e;

  // Vector k sits at base + 8*k.
  function automatic logic [15:0] vec_addr(input logic [15:0] base,
                                           input logic [2:0]  src);
    return base + {10'd0, src, 3'b000};
  endfunction

  // Hardware-cleared flags: timers always, external ints only when
  // edge-triggered (a level source must be cleared by the device itself),
  // serial never (software owns RI/TI).
  function automatic logic [3:0] clr_mask(input logic [2:0] src,
                                          input logic [1:0] it);
    logic [3:0] m;
    m = 4'b0000;
    case (src)
      SRC_IE0: m = {3'b000, it[0]};
      SRC_TF0: m = 4'b0010;
      SRC_IE1: m = {1'b0, it[1], 2'b00};
      SRC_TF1: m = 4'b1000;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Two-level interrupt priority encoder (purely combinational).
// Any eligible high-priority source beats any low-priority one; within a
// level the lowest index wins. Also used by the debug SFR read path.
// Ports:
//   elig   in  eligible source mask
//   ip     in  per-source priority (1 = high)
//   valid  out at least one source eligible
//   winner out index of the winning source (0 when none)
module int_prio_enc
  import mcu_pkg::*;
(
  input  logic [INT_NSRC-1:0] elig,
  input  logic [INT_NSRC-1:0] ip,
  output logic                valid,
  output logic [2:0]          winner
);

  logic [INT_NSRC-1:0] hi;
  logic [INT_NSRC-1:0] lo;
  logic [INT_NSRC-1:0] pick;

  always_comb begin
    hi     = elig & ip;
    lo     = elig & ~ip;
    pick   = (|hi) ? hi : lo;
    valid  = |elig;
    winner = 3'd0;
    // Descending scan: the last hit is the lowest index.
    for (int k = INT_NSRC - 1; k >= 0; k--) begin
      if (pick[k]) winner = 3'(k);
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt sequencing controller for the 8051 core.
// Sits between the SFR block and the instruction sequencer: resolves
// two-level priority, holds a registered request/vector handshake,
// tracks in-service nesting, pulses hardware flag clears and enforces the
// one-instruction block after RETI or an IE/IP write.
//
// Ports:
//   clk          in   core clock
//   rst_n        in   synchronous active-low reset
//   ie[7:0]      in   IE SFR (bit7 EA, bits4:0 enables)
//   ip[4:0]      in   IP SFR (1 = high priority)
//   it[1:0]      in   TCON IT1/IT0 (1 = edge-triggered)
//   flag[4:0]    in   raw pending flags {RI|TI, TF1, IE1, TF0, IE0}
//   sfr_ie_ip_wr in   core wrote IE or IP this cycle
//   instr_done   in   instruction boundary pulse
//   reti         in   RETI executed pulse
//   int_ack      in   core accepts the current request
//   int_req      out  registered request to core
//   int_vector   out  LCALL target of current request
//   int_src      out  index of current request
//   flag_clr     out  one-cycle clear pulses {TF1, IE1, TF0, IE0}
//   in_svc       out  {high, low} in-service bits
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no request outstanding; launch when a winner exists, not blocked
// REQ   | int_req high; re-arbitrates each cycle until ack or withdrawal
// ACK   | one cycle after acceptance; clear pulses out, then back to IDLE
module int_ctrl
  import mcu_pkg::*;
#(
  parameter logic [15:0] VEC_BASE = INT_VEC_BASE,
  parameter int          NSRC     = INT_NSRC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      ie,
  input  logic [NSRC-1:0] ip,
  input  logic [1:0]      it,
  input  logic [NSRC-1:0] flag,
  input  logic            sfr_ie_ip_wr,
  input  logic            instr_done,
  input  logic            reti,
  input  logic            int_ack,
  output logic            int_req,
  output logic [15:0]     int_vector,
  output logic [2:0]      int_src,
  output logic [3:0]      flag_clr,
  output logic [1:0]      in_svc
);

  int_state_e      state;
  int_state_e      state_next;
  logic            block_armed;
  logic            block_next;
  logic            req_next;
  logic [15:0]     vec_next;
  logic [2:0]      src_next;
  logic [3:0]      clr_next;
  logic [1:0]      svc_next;

  logic [NSRC-1:0] elig;
  logic            win_valid;
  logic [2:0]      win_src;
  logic            blocked;
  logic            cur_hi;

  // IE bits 6:5 are reserved on this core.
  logic            unused_ie;
  assign unused_ie = ^ie[6:5];

  // A high source is masked only by a high service in progress; a low
  // source is masked by any service in progress.
  always_comb begin
    elig = '0;
    for (int k = 0; k < NSRC; k++) begin
      elig[k] = ie[7] & ie[k] & flag[k] &
                (ip[k] ? ~in_svc[1] : ~(in_svc[1] | in_svc[0]));
    end
  end

  int_prio_enc u_prio (
    .elig   (elig),
    .ip     (ip),
    .valid  (win_valid),
    .winner (win_src)
  );

  // The arming cycle itself also blocks, so a write or RETI never lets a
  // stale request slip through on the same edge.
  assign blocked = block_armed | reti | sfr_ie_ip_wr;

  // Priority level of the registered request, taken from ip at ack time.
  always_comb begin
    cur_hi = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (int_src == 3'(k)) cur_hi = ip[k];
    end
  end

  always_comb begin
    state_next = state;
    req_next   = int_req;
    vec_next   = int_vector;
    src_next   = int_src;
    clr_next   = 4'b0000;
    svc_next   = in_svc;
    block_next = block_armed;

    // RETI retires the innermost level first.
    if (reti) begin
      if (in_svc[1])      svc_next[1] = 1'b0;
      else if (in_svc[0]) svc_next[0] = 1'b0;
    end

    // Re-arming (including alongside instr_done) restarts the wait.
    if (reti || sfr_ie_ip_wr) block_next = 1'b1;
    else if (instr_done)      block_next = 1'b0;

    case (state)
      ST_IDLE: begin
        if (win_valid && !blocked) begin
          state_next = ST_REQ;
          req_next   = 1'b1;
          src_next   = win_src;
          vec_next   = vec_addr(VEC_BASE, win_src);
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          // Ack beats withdrawal; the source serviced is the registered one.
          state_next       = ST_ACK;
          req_next         = 1'b0;
          clr_next         = clr_mask(int_src, it);
          svc_next[cur_hi] = 1'b1;
        end else if (win_valid) begin
          src_next = win_src;
          vec_next = vec_addr(VEC_BASE, win_src);
        end else begin
          state_next = ST_IDLE;
          req_next   = 1'b0;
        end
      end
      ST_ACK: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      int_req     <= 1'b0;
      int_vector  <= VEC_BASE;
      int_src     <= 3'd0;
      flag_clr    <= 4'b0000;
      in_svc      <= 2'b00;
      block_armed <= 1'b0;
    end else begin
      state       <= state_next;
      int_req     <= req_next;
      int_vector  <= vec_next;
      int_src     <= src_next;
      flag_clr    <= clr_next;
      in_svc      <= svc_next;
      block_armed <= block_next;
    end
  end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Interrupt sequencing controller for the 8051 core. It sits between the SFR block (IE, IP, TCON, SCON flags) and the instruction sequencer.
- It resolves two-level priority (per-source IP bit, then fixed order) and holds a registered request/vector handshake with the core.
- It tracks the in-service nesting level and issues flag-clear pulses for hardware-cleared sources.
- It enforces the one-instruction block after RETI or an IE/IP write.

Parameters:
- VEC_BASE, 16'h0003, address of vector 0; vector k = VEC_BASE + 8*k.
- NSRC, 5, number of sources (IE0, TF0, IE1, TF1, serial); fixed, used for width only.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- ie  in  8  IE SFR; bit7 EA, bits4:0 source enables
- ip  in  5  IP SFR bits4:0; 1 = high priority
- it  in  2  TCON IT0/IT1; 1 = edge-triggered external int
- flag  in  5  {RI|TI, TF1, IE1, TF0, IE0} raw pending flags
- sfr_ie_ip_wr  in  1  pulse: core wrote IE or IP this cycle
- instr_done  in  1  pulse: core completed an instruction (boundary)
- reti  in  1  pulse: core executed RETI
- int_ack  in  1  core accepts the current request at a boundary
- int_req  out  1  registered interrupt request to core
- int_vector  out  16  LCALL target for current request
- int_src  out  3  index 0..4 of current request
- flag_clr  out  4  one-cycle clear pulses {TF1, IE1, TF0, IE0}
- in_svc  out  2  {high, low} in-service bits

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - int_req=0, int_vector=VEC_BASE, int_src=0, flag_clr=0, in_svc=0.
  - block counter cleared; state IDLE.
- Eligibility, combinational: src k is eligible when EA & ie[k] & flag[k] and it passes the nesting check.
  - High (ip[k]=1) is blocked when in_svc[1]=1.
  - Low is blocked when in_svc[1] or in_svc[0] is 1.
- Winner selection:
  - Any eligible high source beats any low source.
  - Within a level, order is 0>1>2>3>4.
- States:
  - IDLE:
    - Winner exists and not blocked -> REQ next cycle.
    - int_req=1 and int_vector/int_src registered from the winner.
    - Latency is flag rise at edge N -> int_req high after edge N+1.
  - REQ:
    - Re-arbitrate every cycle; int_vector/int_src follow the winner, so a higher source arriving late preempts before ack.
    - No winner (flag dropped, EA cleared, nesting change) -> IDLE with int_req=0 next cycle.
    - int_ack=1 -> ACK. The serviced source is the int_src registered at that edge.
  - ACK, one cycle:
    - int_req=0.
    - Set in_svc[ip[src]].
    - flag_clr pulse: TF0/TF1 always; IE0/IE1 only when the matching it bit=1.
    - Serial (src 4) is never cleared.
    - -> IDLE.
- int_ack while int_req=0 is ignored.
- int_ack in the same cycle that the request withdraws: ack wins, and the registered int_src is serviced.
- reti pulse:
  - Clears in_svc[1] if set, else in_svc[0]; ignored when in_svc=0.
  - Arms the block.
- Block:
  - Armed by reti or sfr_ie_ip_wr.
  - While armed, IDLE does not go to REQ.
  - Disarmed by the first instr_done strictly after the arming cycle.
  - reti and instr_done in the same cycle: block stays armed.
  - Re-arming while armed restarts the wait.
- Simultaneous int_ack and reti: ack takes priority for the state transition; both in_svc updates are applied (clear the old level, then set the new one).
- An ip change mid-service does not move the in_svc bits.
- Reset mid-operation: everything returns to reset values; no flag_clr is issued.

Decomposition:
- Shared package (mcu_pkg):
  - source index constants SRC_IE0..SRC_SER;
  - VEC_BASE, vector stride 8;
  - state encoding IDLE/REQ/ACK.
- Sub-module int_prio_enc: purely combinational.
  - Inputs: eligible mask and ip.
  - Outputs: valid, 3-bit winner.
  - Reusable by the debug SFR read path.

Test Plan:
- Reset with all flags set, then rst_n=1, EA=1, ie=8'h9F, ip=0:
  - int_req=1 two edges after release, int_vector=0003, int_src=0.
- flag=5'b01010 (TF0, TF1), ip[3]=1:
  - int_src=3, vector=001B.
  - On int_ack: flag_clr=4'b1000 for one cycle, in_svc=2'b10.
- in_svc=2'b01 (low serial in service), IE1 low prio pending: no req.
  - Set ip[2]=1 via write plus instr_done: req with vector=0013.
- Request withdrawn in REQ (EA dropped before ack): int_req=0 next cycle.
  - int_ack pulsed later: no state change, flag_clr=0.
- IE0 level-triggered (it[0]=0) acked: flag_clr[0]=0.
  - Same with it[0]=1: flag_clr[0]=1.
- RETI with flag pending: no req until the next instr_done, then req one cycle later.
  - RETI and instr_done together: block holds until the following instr_done.
